pipe_signed_divider: RTL and testbench
======================================

PIPE_SIGNED_DIVIDER -- requirements
Module: pipe_signed_divider

Interface
REQ-001 SHALL have parameter W, default 8: operand width in bits; legal range 4..32.
REQ-002 SHALL have parameter SIGNED_MODE, default 1: 1 means two's-complement operands, 0 means unsigned operands.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: dividend and divisor are presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the pipeline accepts an operand pair this cycle.
REQ-007 SHALL have port dividend, input, W bits: numerator.
REQ-008 SHALL have port divisor, input, W bits: denominator.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 SHALL have port quotient, output, W bits: result quotient.
REQ-012 SHALL have port remainder, output, W bits: result remainder.
REQ-013 SHALL have port div_by_zero, output, 1 bit: the result came from divisor == 0.

Function
REQ-014 SHALL define the pipeline as W+2 register stages: S0 (magnitude/sign capture), S1..SW (one restoring iteration each), SW+1 (sign fix/output).
REQ-015 SHALL compute a global advance enable: adv = !out_valid || out_ready.
REQ-016 SHALL drive in_ready = adv combinationally; an operand pair is accepted when in_valid && in_ready.
REQ-017 SHALL shift every stage and its valid bit one position forward when adv = 1; when adv = 0, all stages hold.
REQ-018 SHALL have S0 capture |dividend| and |divisor| as W-bit unsigned magnitudes (two's-complement negate when SIGNED_MODE=1 and the MSB is set).
REQ-019 SHALL have S0 also capture the dividend sign, the divisor sign and a zero-divisor flag.
REQ-020 SHALL have each iteration stage operate on a 2W-bit work register {partial remainder, quotient bits}.
REQ-021 SHALL have each iteration stage shift the work register left by 1 bit.
REQ-022 SHALL have each iteration stage compare the upper W+1 bits against the divisor magnitude.
REQ-023 SHALL, when that compare gives upper >= divisor, subtract the divisor magnitude from the upper bits and set the LSB to 1; otherwise the LSB is 0.
REQ-024 SHALL carry the signs, zero flag, divisor magnitude and valid bit through every stage alongside the work register.
REQ-025 SHALL apply truncating-division signs: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
REQ-026 SHALL, for a divisor of 0, output quotient = all ones, remainder = the original dividend, div_by_zero = 1.
REQ-027 SHALL, for the most-negative value / -1 (signed), output quotient = most-negative, remainder = 0, div_by_zero = 0.
REQ-028 SHALL give a latency of exactly W+2 cycles from acceptance to out_valid, with no stall in between.
REQ-029 SHALL give a throughput of one result per cycle while out_ready = 1.
REQ-030 SHALL, when out_ready is held low, hold quotient, remainder and div_by_zero stable.
REQ-031 SHALL never drop or duplicate an accepted operand pair.
REQ-032 SHALL hold the upstream stages' contents when out_valid = 1 and out_ready = 0, with in_ready = 0.

Reset
REQ-033 SHALL, while rst = 1 at a clock edge, clear all stage valid bits, out_valid, quotient, remainder and div_by_zero to 0.
REQ-034 SHALL drive in_ready to 1 during reset, following REQ-015 (out_valid = 0); pairs offered while rst = 1 are discarded.
REQ-035 SHALL discard all in-flight operations when reset is applied mid-operation; no stale result appears after rst falls.
REQ-036 SHALL accept a new operand pair on the first cycle after rst falls.

Structure
REQ-037 SHALL place in package div_pkg: the stage-count function (W+2), the most-negative constant function and the work-register type/width constant.
REQ-038 SHALL implement one iteration stage as sub-module div_iter_stage (parameter W), instantiated W times by generate.
REQ-039 SHALL keep S0 and the output stage in the top module.

Verification (W=8, SIGNED_MODE=1)
REQ-040 SHALL check: -100/7 -> quotient 0xF2 (-14), remainder 0xFE (-2), div_by_zero 0, out_valid exactly 10 cycles after acceptance.
REQ-041 SHALL check: 100/-7 -> quotient -14, remainder 2; -100/-7 -> quotient 14, remainder -2, back-to-back, results in order on consecutive cycles.
REQ-042 SHALL check: -128/-1 -> quotient 0x80, remainder 0.
REQ-043 SHALL check: 5/0 -> quotient 0xFF, remainder 5, div_by_zero 1.
REQ-044 SHALL check: stream 20 random pairs with out_ready toggled pseudo-randomly -> every result matches a reference model, in order, with outputs stable while stalled.
REQ-045 SHALL check: assert rst for 1 cycle with 5 pairs in flight -> no out_valid for those pairs; a pair accepted after reset completes with correct values after 10 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Sizing helpers shared by the pipelined restoring divider and its iteration stages.
package div_pkg;

    localparam int MAX_W = 32;

    // Total register stages: operand capture, one per quotient bit, sign fix.
    function automatic int stage_count(input int w);
        return w + 2;
    endfunction

    // Work register holds {partial remainder, quotient bits}.
    function automatic int work_width(input int w);
        return 2 * w;
    endfunction

    function automatic logic [MAX_W-1:0] most_neg(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/div_iter_stage.sv
// One restoring-division step: shift {rem, quo} left by one, trial-subtract the divisor magnitude.
module div_iter_stage
    import div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     adv_i,
    input  logic                     valid_i,
    input  logic [work_width(W)-1:0] work_i,
    input  logic [W-1:0]             dmag_i,
    input  logic                     nsign_i,
    input  logic                     dsign_i,
    input  logic                     zero_i,
    output logic                     valid_o,
    output logic [work_width(W)-1:0] work_o,
    output logic [W-1:0]             dmag_o,
    output logic                     nsign_o,
    output logic                     dsign_o,
    output logic                     zero_o
);
    localparam int WW = work_width(W);

    logic [W:0]    upper;
    logic [W-1:0]  diff;
    logic          ge;
    logic [WW-1:0] work_d;

    // The difference is below the divisor whenever it is kept, so W bits suffice.
    always_comb begin
        upper  = work_i[WW-1:W-1];
        diff   = upper[W-1:0] - dmag_i;
        ge     = (upper >= {1'b0, dmag_i});
        work_d = {(ge ? diff : upper[W-1:0]), work_i[W-2:0], ge};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            work_o  <= '0;
            dmag_o  <= '0;
            nsign_o <= 1'b0;
            dsign_o <= 1'b0;
            zero_o  <= 1'b0;
        end else if (adv_i) begin
            valid_o <= valid_i;
            work_o  <= work_d;
            dmag_o  <= dmag_i;
            nsign_o <= nsign_i;
            dsign_o <= dsign_i;
            zero_o  <= zero_i;
        end
    end

endmodule

// File: rtl/pipe_signed_divider.sv
// Fully pipelined W-bit divider: magnitude capture, W restoring steps, truncating sign fix.
// Handshake: a stage moves whenever the output register is empty or being taken (adv).
module pipe_signed_divider
    import div_pkg::*;
#(
    parameter int W           = 8,
    parameter int SIGNED_MODE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);
    localparam int NIT = stage_count(W) - 2;
    localparam int WW  = work_width(W);

    logic         adv;
    logic         out_valid_q;
    logic [W-1:0] quotient_q, remainder_q;
    logic         dbz_q;

    assign adv         = !out_valid_q || out_ready;
    assign in_ready    = adv;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

    logic n_neg, d_neg;
    assign n_neg = (SIGNED_MODE != 0) && dividend[W-1];
    assign d_neg = (SIGNED_MODE != 0) && divisor[W-1];

    logic         s0_valid_q, s0_nsign_q, s0_dsign_q, s0_zero_q;
    logic [W-1:0] s0_nmag_q, s0_dmag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_nmag_q  <= '0;
            s0_dmag_q  <= '0;
            s0_nsign_q <= 1'b0;
            s0_dsign_q <= 1'b0;
            s0_zero_q  <= 1'b0;
        end else if (adv) begin
            s0_valid_q <= in_valid;
            s0_nmag_q  <= n_neg ? -dividend : dividend;
            s0_dmag_q  <= d_neg ? -divisor : divisor;
            s0_nsign_q <= n_neg;
            s0_dsign_q <= d_neg;
            s0_zero_q  <= (divisor == '0);
        end
    end

    logic [NIT:0]         v_c, nsign_c, dsign_c, zero_c;
    logic [NIT:0][WW-1:0] work_c;
    logic [NIT:0][W-1:0]  dmag_c;

    assign v_c[0]     = s0_valid_q;
    assign work_c[0]  = {{W{1'b0}}, s0_nmag_q};
    assign dmag_c[0]  = s0_dmag_q;
    assign nsign_c[0] = s0_nsign_q;
    assign dsign_c[0] = s0_dsign_q;
    assign zero_c[0]  = s0_zero_q;

    for (genvar i = 0; i < NIT; i++) begin : g_iter
        div_iter_stage #(.W(W)) u_stage (
            .clk_i   (clk),
            .rst_i   (rst),
            .adv_i   (adv),
            .valid_i (v_c[i]),
            .work_i  (work_c[i]),
            .dmag_i  (dmag_c[i]),
            .nsign_i (nsign_c[i]),
            .dsign_i (dsign_c[i]),
            .zero_i  (zero_c[i]),
            .valid_o (v_c[i+1]),
            .work_o  (work_c[i+1]),
            .dmag_o  (dmag_c[i+1]),
            .nsign_o (nsign_c[i+1]),
            .dsign_o (dsign_c[i+1]),
            .zero_o  (zero_c[i+1])
        );
    end

    logic [W-1:0] qmag, rmag, quotient_d, remainder_d;
    logic         dbz_d;

    // A zero divisor leaves the dividend magnitude in the remainder, so only the quotient is forced.
    always_comb begin
        qmag        = work_c[NIT][W-1:0];
        rmag        = work_c[NIT][WW-1:W];
        dbz_d       = zero_c[NIT];
        quotient_d  = (nsign_c[NIT] ^ dsign_c[NIT]) ? -qmag : qmag;
        remainder_d = nsign_c[NIT] ? -rmag : rmag;
        if (dmag_c[NIT] == '0) begin
            quotient_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v_c[NIT];
            if (v_c[NIT]) begin
                quotient_q  <= quotient_d;
                remainder_q <= remainder_d;
                dbz_q       <= dbz_d;
            end
        end
    end

endmodule

// File: tb/tb_pipe_signed_divider.sv
// Directed and streamed stimulus for pipe_signed_divider (W=8, signed) against an arithmetic model.
module tb_pipe_signed_divider;
    import div_pkg::*;

    localparam int W   = 8;
    localparam int LAT = 10;

    logic         clk, rst, in_valid, in_ready, out_valid, out_ready, div_by_zero;
    logic [W-1:0] dividend, divisor, quotient, remainder;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   lat_mode = 1'b1;
    bit   rand_ready = 1'b0;
    bit   stall_prev = 1'b0;
    logic [2*W:0] held;
    logic [2*W:0] exp_q[$];
    int           acc_q[$];

    pipe_signed_divider #(.W(W), .SIGNED_MODE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Clock / cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Truncating division; result packed as {div_by_zero, quotient, remainder}.
    function automatic logic [2*W:0] model(input logic [W-1:0] n, input logic [W-1:0] d);
        int ni, di, qi, ri;
        logic [W-1:0] qv, rv;
        ni = int'($signed(n));
        di = int'($signed(d));
        if (di == 0) return {1'b1, {W{1'b1}}, n};
        if (ni == -int'(most_neg(W)) && di == -1) return {1'b0, n, {W{1'b0}}};
        qi = ni / di;
        ri = ni % di;
        qv = qi[W-1:0];
        rv = ri[W-1:0];
        return {1'b0, qv, rv};
    endfunction

    task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard / compare process
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", {div_by_zero, quotient, remainder}, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got q=%h r=%h dz=%b expected no result", quotient, remainder, div_by_zero);
                end else begin
                    logic [2*W:0] e;
                    int a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("result", {div_by_zero, quotient, remainder}, e);
                    if (lat_mode) check("latency", (2*W+1)'(cyc - a), LAT);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(dividend, divisor));
                acc_q.push_back(cyc);
            end
            stall_prev = out_valid && !out_ready;
            held = {div_by_zero, quotient, remainder};
        end
    end

    // Consumer back-pressure driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Driver tasks (entered just after a rising edge)
    task automatic send(input logic [W-1:0] n, input logic [W-1:0] d, output int waited);
        in_valid = 1'b1;
        dividend = n;
        divisor  = d;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%b expected 1 within 200 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drain_done", exp_q.size() == 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        logic [W-1:0] n, d;
        rst      = 1'b1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 1);
        check("out_valid_in_reset", out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out", {out_valid, div_by_zero, quotient, remainder}, 0);

        check("pin_m100_d7", model(8'h9C, 8'h07), {1'b0, 8'hF2, 8'hFE});
        check("pin_100_dm7", model(8'h64, 8'hF9), {1'b0, 8'hF2, 8'h02});
        check("pin_m100_dm7", model(8'h9C, 8'hF9), {1'b0, 8'h0E, 8'hFE});
        check("pin_m128_dm1", model(8'h80, 8'hFF), {1'b0, 8'h80, 8'h00});
        check("pin_5_d0", model(8'h05, 8'h00), {1'b1, 8'hFF, 8'h05});
        check("pin_m25_d4", model(8'hE7, 8'h04), {1'b0, 8'hFA, 8'hFF});
        @(posedge clk);
        #1;

        // Directed vectors with out_ready held high: latency checked on each result
        send(8'h9C, 8'h07, w);
        drain();
        send(8'h64, 8'hF9, w);
        send(8'h9C, 8'hF9, w);
        send(8'h80, 8'hFF, w);
        send(8'h05, 8'h00, w);
        drain();

        // Stream with random back-pressure
        lat_mode   = 1'b0;
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            n = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
            d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            send(n, d, w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rand_ready = 1'b0;
        lat_mode   = 1'b1;
        @(posedge clk);
        #1;

        // Flush five in-flight pairs (plus one offered during reset)
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h10 + i), 8'h03, w);
        end
        in_valid = 1'b1;
        dividend = 8'h01;
        divisor  = 8'h01;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        send(8'hE7, 8'h04, w);
        check("accept_after_reset", w, 0);
        drain();
        repeat (15) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
